mshr: RTL



---
 rtl/mshr_pkg.sv | 29 ++
 rtl/mshr_entry.sv | 49 ++++
 rtl/mshr.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mshr_pkg.sv
// mshr_pkg: shared types and constants for the two-entry miss status
// holding register.
//   entry_t            - contents of one queue slot
//   state_e            - memory-side sequencer states
//   MSHR_INVALID_ADDR  - address shown for an unoccupied slot; it is not
//                        word-aligned, so it never matches a cache access
package mshr_pkg;

    localparam logic [31:0] MSHR_INVALID_ADDR = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_RD   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic        valid;
        logic        has_load;
        logic        has_evict;
        logic [31:0] load_addr;
        logic [31:0] evict_addr;
        logic [31:0] evict_data;
        logic [4:0]  regd;
        logic        way;
    } entry_t;

endpackage

// File: rtl/mshr_entry.sv
// mshr_entry: one MSHR storage slot.
//   clk, rst_n     - clock, asynchronous active-low reset
//   we_i           - load wdata_i into the slot (wins over clr_i)
//   clr_i          - free the slot
//   wdata_i        - entry written on we_i
//   entry_o        - stored entry
//   load_addr_o    - stored load address, or INVALID_ADDR if the slot is
//                    empty or carries no load
//   evict_addr_o   - stored evict address, or INVALID_ADDR if the slot is
//                    empty or carries no eviction
module mshr_entry
    import mshr_pkg::*;
#(
    parameter logic [31:0] INVALID_ADDR = MSHR_INVALID_ADDR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_i,
    input  logic        clr_i,
    input  entry_t      wdata_i,
    output entry_t      entry_o,
    output logic [31:0] load_addr_o,
    output logic [31:0] evict_addr_o
);

    entry_t entry_q, entry_d;

    always_comb begin
        entry_d = entry_q;
        if (we_i) begin
            entry_d = wdata_i;
        end else if (clr_i) begin
            entry_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry_o      = entry_q;
    assign load_addr_o  = (entry_q.valid && entry_q.has_load)  ? entry_q.load_addr  : INVALID_ADDR;
    assign evict_addr_o = (entry_q.valid && entry_q.has_evict) ? entry_q.evict_addr : INVALID_ADDR;

endmodule

// File: rtl/mshr.sv
// mshr: two-entry miss status holding register between the data cache and
// the memory bus. Load misses and dirty evictions are queued in arrival
// order; the head entry is serviced as writeback first, then line fill, over
// a single-word req/ready port. Each completed load returns a one-cycle done
// pulse.
//   clk, rst_n                 - clock, asynchronous active-low reset
//   load_valid, evict_valid    - allocation pulse (either or both)
//   addr_load, addr_evict      - fill / writeback word addresses
//   evict_data                 - writeback data
//   mshr_regD_in, load_way_in  - load destination register and fill way
//   addr1..addr4               - slot0 load/evict, slot1 load/evict addresses
//   mshr_done_pulse            - a load has completed (one cycle)
//   mshr_addr_out/data_out/regD_out, load_way_out - completed load info
//   mshr_full                  - every slot occupied
//   mem_req/we/addr/wdata      - memory request, held until mem_ready
//   mem_ready, mem_rdata       - memory completion and read data
module mshr
    import mshr_pkg::*;
#(
    parameter int          NUM_ENTRIES  = 2,
    parameter logic [31:0] INVALID_ADDR = MSHR_INVALID_ADDR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    input  logic        evict_valid,
    input  logic [31:0] addr_load,
    input  logic [31:0] addr_evict,
    input  logic [31:0] evict_data,
    input  logic [4:0]  mshr_regD_in,
    input  logic        load_way_in,
    output logic [31:0] addr1,
    output logic [31:0] addr2,
    output logic [31:0] addr3,
    output logic [31:0] addr4,
    output logic        mshr_done_pulse,
    output logic [31:0] mshr_addr_out,
    output logic [31:0] mshr_data_out,
    output logic [4:0]  mshr_regD_out,
    output logic        load_way_out,
    output logic        mshr_full,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int PTR_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    entry_t [NUM_ENTRIES-1:0]       ent;
    logic   [NUM_ENTRIES-1:0][31:0] ld_addr_m;
    logic   [NUM_ENTRIES-1:0][31:0] ev_addr_m;
    logic   [NUM_ENTRIES-1:0]       ent_we;
    logic   [NUM_ENTRIES-1:0]       ent_clr;
    logic   [NUM_ENTRIES-1:0]       ent_valid;

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q, tail_d;
    state_e           state_q;

    entry_t head_ent;
    entry_t alloc_ent;
    logic   full;
    logic   alloc;
    logic   retire;

    logic        mem_req_q, mem_we_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic        done_q;
    logic [31:0] done_addr_q, done_data_q;
    logic [4:0]  done_regd_q;
    logic        done_way_q;

    // ---------------------------------------------------------------
    // Allocation at the tail
    // ---------------------------------------------------------------
    assign full     = &ent_valid;
    assign alloc    = (load_valid || evict_valid) && !full;
    assign head_ent = ent[head_q];

    always_comb begin
        alloc_ent            = '0;
        alloc_ent.valid      = 1'b1;
        alloc_ent.has_load   = load_valid;
        alloc_ent.has_evict  = evict_valid;
        alloc_ent.load_addr  = addr_load;
        alloc_ent.evict_addr = addr_evict;
        alloc_ent.evict_data = evict_data;
        alloc_ent.regd       = mshr_regD_in;
        alloc_ent.way        = load_way_in;
    end

    always_comb begin
        tail_d = tail_q;
        if (alloc) begin
            tail_d = tail_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tail_q <= '0;
        end else begin
            tail_q <= tail_d;
        end
    end

    // The head is released either when a writeback-only entry finishes or
    // at the end of the done cycle. The slot cannot be the tail target in
    // the same cycle: a valid head equal to the tail means the queue is full.
    assign retire = (state_q == ST_DONE) ||
                    ((state_q == ST_WB) && mem_ready && !head_ent.has_load);

    // ---------------------------------------------------------------
    // Storage slots
    // ---------------------------------------------------------------
    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_ent
        assign ent_we[i]    = alloc  && (tail_q == PTR_W'(i));
        assign ent_clr[i]   = retire && (head_q == PTR_W'(i));
        assign ent_valid[i] = ent[i].valid;

        mshr_entry #(
            .INVALID_ADDR (INVALID_ADDR)
        ) u_entry (
            .clk          (clk),
            .rst_n        (rst_n),
            .we_i         (ent_we[i]),
            .clr_i        (ent_clr[i]),
            .wdata_i      (alloc_ent),
            .entry_o      (ent[i]),
            .load_addr_o  (ld_addr_m[i]),
            .evict_addr_o (ev_addr_m[i])
        );
    end

    // ---------------------------------------------------------------
    // Memory sequencer. Request and done outputs are registered so no
    // input reaches an output combinationally.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            head_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            done_addr_q <= '0;
            done_data_q <= '0;
            done_regd_q <= '0;
            done_way_q  <= 1'b0;
        end else begin
            // done outputs are zero except in the single done cycle
            done_q      <= 1'b0;
            done_addr_q <= '0;
            done_data_q <= '0;
            done_regd_q <= '0;
            done_way_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (head_ent.valid) begin
                        mem_req_q <= 1'b1;
                        if (head_ent.has_evict) begin
                            state_q     <= ST_WB;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= head_ent.evict_addr;
                            mem_wdata_q <= head_ent.evict_data;
                        end else begin
                            state_q     <= ST_RD;
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= head_ent.load_addr;
                            mem_wdata_q <= '0;
                        end
                    end
                end
                ST_WB: begin
                    if (mem_ready) begin
                        mem_wdata_q <= '0;
                        mem_we_q    <= 1'b0;
                        if (head_ent.has_load) begin
                            // request stays up; the fill follows immediately
                            state_q    <= ST_RD;
                            mem_addr_q <= head_ent.load_addr;
                        end else begin
                            state_q    <= ST_IDLE;
                            mem_req_q  <= 1'b0;
                            mem_addr_q <= '0;
                            head_q     <= head_q + PTR_W'(1);
                        end
                    end
                end
                ST_RD: begin
                    if (mem_ready) begin
                        state_q     <= ST_DONE;
                        mem_req_q   <= 1'b0;
                        mem_addr_q  <= '0;
                        done_q      <= 1'b1;
                        done_addr_q <= head_ent.load_addr;
                        done_data_q <= mem_rdata;
                        done_regd_q <= head_ent.regd;
                        done_way_q  <= head_ent.way;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    head_q  <= head_q + PTR_W'(1);
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign addr1 = ld_addr_m[0];
    assign addr2 = ev_addr_m[0];
    assign addr3 = ld_addr_m[1];
    assign addr4 = ev_addr_m[1];

    assign mshr_full       = full;
    assign mshr_done_pulse = done_q;
    assign mshr_addr_out   = done_addr_q;
    assign mshr_data_out   = done_data_q;
    assign mshr_regD_out   = done_regd_q;
    assign load_way_out    = done_way_q;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
